// File: rtl/gtx_8b10b_pkg.sv
// Shared 8b/10b constants and sub-block lookup helpers for the GTX receive decoder.
// Sub-block codes are written in wire order (abcdei / fghj, leftmost bit sent first).
package gtx_8b10b_pkg;

  localparam logic RD_NEG = 1'b0;
  localparam logic RD_POS = 1'b1;

  localparam logic [4:0] K28_X = 5'd28;
  localparam logic [7:0] K23_7 = 8'hF7;
  localparam logic [7:0] K27_7 = 8'hFB;
  localparam logic [7:0] K29_7 = 8'hFD;
  localparam logic [7:0] K30_7 = 8'hFE;

  localparam logic [5:0] K28_6B_RDN = 6'b001111;
  localparam logic [5:0] K28_6B_RDP = 6'b110000;

  // Balanced sub-blocks that are only legal when entered at one particular RD.
  localparam logic [5:0] B6_RDN_ONLY = 6'b111000;
  localparam logic [5:0] B6_RDP_ONLY = 6'b000111;
  localparam logic [3:0] B4_RDN_ONLY = 4'b1100;
  localparam logic [3:0] B4_RDP_ONLY = 4'b0011;

  typedef struct packed {
    logic       legal;
    logic [4:0] val;
  } sub6_t;

  typedef struct packed {
    logic       legal;
    logic       alt7;
    logic [2:0] val;
  } sub4_t;

  function automatic logic [3:0] cnt_ones10(logic [9:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int i = 0; i < 10; i++) n = n + {3'd0, v[i]};
    return n;
  endfunction

  function automatic logic [2:0] cnt_ones6(logic [5:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 6; i++) n = n + {2'd0, v[i]};
    return n;
  endfunction

  function automatic logic [2:0] cnt_ones4(logic [3:0] v);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) n = n + {2'd0, v[i]};
    return n;
  endfunction

  // Both disparity forms of each 5b value map to the same EDCBA.
  function automatic sub6_t dec6(logic [5:0] c);
    sub6_t r;
    r.legal = 1'b1;
    r.val   = 5'd0;
    case (c)
      6'b100111, 6'b011000: r.val = 5'd0;
      6'b011101, 6'b100010: r.val = 5'd1;
      6'b101101, 6'b010010: r.val = 5'd2;
      6'b110001:            r.val = 5'd3;
      6'b110101, 6'b001010: r.val = 5'd4;
      6'b101001:            r.val = 5'd5;
      6'b011001:            r.val = 5'd6;
      6'b111000, 6'b000111: r.val = 5'd7;
      6'b111001, 6'b000110: r.val = 5'd8;
      6'b100101:            r.val = 5'd9;
      6'b010101:            r.val = 5'd10;
      6'b110100:            r.val = 5'd11;
      6'b001101:            r.val = 5'd12;
      6'b101100:            r.val = 5'd13;
      6'b011100:            r.val = 5'd14;
      6'b010111, 6'b101000: r.val = 5'd15;
      6'b011011, 6'b100100: r.val = 5'd16;
      6'b100011:            r.val = 5'd17;
      6'b010011:            r.val = 5'd18;
      6'b110010:            r.val = 5'd19;
      6'b001011:            r.val = 5'd20;
      6'b101010:            r.val = 5'd21;
      6'b011010:            r.val = 5'd22;
      6'b111010, 6'b000101: r.val = 5'd23;
      6'b110011, 6'b001100: r.val = 5'd24;
      6'b100110:            r.val = 5'd25;
      6'b010110:            r.val = 5'd26;
      6'b110110, 6'b001001: r.val = 5'd27;
      6'b001110:            r.val = 5'd28;
      6'b101110, 6'b010001: r.val = 5'd29;
      6'b011110, 6'b100001: r.val = 5'd30;
      6'b101011, 6'b010100: r.val = 5'd31;
      6'b001111, 6'b110000: r.val = K28_X;
      default:              r.legal = 1'b0;
    endcase
    return r;
  endfunction

  function automatic sub4_t dec4(logic [3:0] c);
    sub4_t r;
    r.legal = 1'b1;
    r.alt7  = 1'b0;
    r.val   = 3'd0;
    case (c)
      4'b1011, 4'b0100: r.val = 3'd0;
      4'b1001:          r.val = 3'd1;
      4'b0101:          r.val = 3'd2;
      4'b1100, 4'b0011: r.val = 3'd3;
      4'b1101, 4'b0010: r.val = 3'd4;
      4'b1010:          r.val = 3'd5;
      4'b0110:          r.val = 3'd6;
      4'b1110, 4'b0001: r.val = 3'd7;
      4'b0111, 4'b1000: begin
        r.val  = 3'd7;
        r.alt7 = 1'b1;
      end
      default:          r.legal = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gtx_10x8dec_sym.sv
// Combinational single-symbol 8b/10b decode: byte, K flag, code/disparity errors
// and the running disparity leaving the symbol.
module gtx_10x8dec_sym import gtx_8b10b_pkg::*; (
  input  logic [9:0] sym,
  input  logic       rd_in,
  output logic [7:0] data,
  output logic       is_k,
  output logic       code_err,
  output logic       disp_err,
  output logic       rd_out
);

  logic [5:0] abcdei;
  logic [3:0] fghj;
  logic [3:0] fghj_lu;
  logic [3:0] n_all;
  logic [2:0] n6;
  logic [2:0] n4;
  sub6_t      s6;
  sub4_t      s4;
  logic [7:0] raw;
  logic       k28;
  logic       kx7;
  logic       rd_mid;
  logic       derr6;
  logic       derr4;

  assign abcdei = {sym[0], sym[1], sym[2], sym[3], sym[4], sym[5]};
  assign fghj   = {sym[6], sym[7], sym[8], sym[9]};

  // K28 in its RD+ form carries the complement of the RD- 4b sub-block.
  assign fghj_lu = (abcdei == K28_6B_RDP) ? ~fghj : fghj;

  assign s6    = dec6(abcdei);
  assign s4    = dec4(fghj_lu);
  assign raw   = {s4.val, s6.val};
  assign n_all = cnt_ones10(sym);
  assign n6    = cnt_ones6(abcdei);
  assign n4    = cnt_ones4(fghj);

  assign k28 = (abcdei == K28_6B_RDN) || (abcdei == K28_6B_RDP);
  assign kx7 = s4.alt7 && ((raw == K23_7) || (raw == K27_7) ||
                           (raw == K29_7) || (raw == K30_7));

  assign code_err = (n_all < 4'd4) || (n_all > 4'd6) || !s6.legal || !s4.legal;

  assign rd_mid = (n6 == 3'd4) ? RD_POS : (n6 == 3'd2) ? RD_NEG : rd_in;

  assign derr6 = ((n6 == 3'd4) && (rd_in == RD_POS)) ||
                 ((n6 == 3'd2) && (rd_in == RD_NEG)) ||
                 ((abcdei == B6_RDN_ONLY) && (rd_in == RD_POS)) ||
                 ((abcdei == B6_RDP_ONLY) && (rd_in == RD_NEG));

  assign derr4 = ((n4 == 3'd3) && (rd_mid == RD_POS)) ||
                 ((n4 == 3'd1) && (rd_mid == RD_NEG)) ||
                 ((fghj == B4_RDN_ONLY) && (rd_mid == RD_POS)) ||
                 ((fghj == B4_RDP_ONLY) && (rd_mid == RD_NEG));

  assign data     = code_err ? 8'h00 : raw;
  assign is_k     = !code_err && (k28 || kx7);
  assign disp_err = !code_err && (derr6 || derr4);

  // Unbalanced symbols resync RD to their own sign even when flagged.
  assign rd_out = code_err       ? rd_in  :
                  (n_all == 4'd6) ? RD_POS :
                  (n_all == 4'd4) ? RD_NEG : rd_in;

endmodule

// File: rtl/gtx_10x8dec.sv
// Two-symbol-per-clock 8b/10b decoder, two-stage pipeline with RD chained across symbols.
// Optional error counters when GTX_10X8DEC_STATS_EN is defined.
module gtx_10x8dec import gtx_8b10b_pkg::*; (
  input  logic        clk,
  input  logic        rst,
  input  logic [19:0] indata,
  output logic [15:0] outdata,
  output logic [1:0]  outisk,
  output logic [1:0]  notintable,
  output logic [1:0]  disperror
`ifdef GTX_10X8DEC_STATS_EN
  ,
  output logic [15:0] err_code_cnt,
  output logic [15:0] err_disp_cnt
`endif
);

  logic [19:0] in_q;
  logic        in_vld;
  logic        rd;
  logic [7:0]  d0, d1;
  logic        k0, k1;
  logic        ce0, ce1;
  logic        de0, de1;
  logic        rd_mid;
  logic        rd_next;
  logic [1:0]  nit_d;
  logic [1:0]  derr_d;

  gtx_10x8dec_sym u_sym0 (
    .sym      (in_q[9:0]),
    .rd_in    (rd),
    .data     (d0),
    .is_k     (k0),
    .code_err (ce0),
    .disp_err (de0),
    .rd_out   (rd_mid)
  );

  gtx_10x8dec_sym u_sym1 (
    .sym      (in_q[19:10]),
    .rd_in    (rd_mid),
    .data     (d1),
    .is_k     (k1),
    .code_err (ce1),
    .disp_err (de1),
    .rd_out   (rd_next)
  );

  // The stage-1 reset value is not a received word, so it never reaches the outputs.
  assign nit_d  = in_vld ? {ce1, ce0} : 2'b00;
  assign derr_d = in_vld ? {de1, de0} : 2'b00;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_q       <= 20'h00000;
      in_vld     <= 1'b0;
      rd         <= RD_NEG;
      outdata    <= 16'h0000;
      outisk     <= 2'b00;
      notintable <= 2'b00;
      disperror  <= 2'b00;
    end else begin
      in_q       <= indata;
      in_vld     <= 1'b1;
      rd         <= in_vld ? rd_next : rd;
      outdata    <= in_vld ? {d1, d0} : 16'h0000;
      outisk     <= in_vld ? {k1, k0} : 2'b00;
      notintable <= nit_d;
      disperror  <= derr_d;
    end
  end

`ifdef GTX_10X8DEC_STATS_EN
  logic [1:0]  nit_n;
  logic [1:0]  derr_n;
  logic [16:0] code_sum;
  logic [16:0] disp_sum;

  assign nit_n    = {1'b0, nit_d[0]} + {1'b0, nit_d[1]};
  assign derr_n   = {1'b0, derr_d[0]} + {1'b0, derr_d[1]};
  assign code_sum = {1'b0, err_code_cnt} + {15'd0, nit_n};
  assign disp_sum = {1'b0, err_disp_cnt} + {15'd0, derr_n};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_code_cnt <= 16'h0000;
      err_disp_cnt <= 16'h0000;
    end else begin
      err_code_cnt <= code_sum[16] ? 16'hFFFF : code_sum[15:0];
      err_disp_cnt <= disp_sum[16] ? 16'hFFFF : disp_sum[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_gtx_10x8dec.sv
// Directed self-checking bench for gtx_10x8dec; counter checks run when
// GTX_10X8DEC_STATS_EN is defined.
module tb_gtx_10x8dec;

  logic        clk;
  logic        rst;
  logic [19:0] indata;
  logic [15:0] outdata;
  logic [1:0]  outisk;
  logic [1:0]  notintable;
  logic [1:0]  disperror;
`ifdef GTX_10X8DEC_STATS_EN
  logic [15:0] err_code_cnt;
  logic [15:0] err_disp_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic [19:0] din;
    logic [15:0] dout;
    logic [1:0]  isk;
    logic [1:0]  nit;
    logic [1:0]  derr;
  } vec_t;

  vec_t tbl[7];
  vec_t seq[$];

  gtx_10x8dec dut (
    .clk        (clk),
    .rst        (rst),
    .indata     (indata),
    .outdata    (outdata),
    .outisk     (outisk),
    .notintable (notintable),
    .disperror  (disperror)
`ifdef GTX_10X8DEC_STATS_EN
    ,
    .err_code_cnt (err_code_cnt),
    .err_disp_cnt (err_disp_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not reach the end, required finish");
    $fatal(1, "timeout");
  end

  function automatic vec_t mk(logic [19:0] din, logic [15:0] dout,
                              logic [1:0] isk, logic [1:0] nit, logic [1:0] derr);
    vec_t v;
    v.din = din; v.dout = dout; v.isk = isk; v.nit = nit; v.derr = derr;
    return v;
  endfunction

  function automatic logic [31:0] cur_out();
    return {10'd0, outdata, outisk, notintable, disperror};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Stream seq back to back; word i driven at negedge i is visible at negedge i+2.
  task automatic play(input string tag);
    int n;
    n = seq.size();
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2)
        chk($sformatf("%s[%0d]", tag, i - 2), cur_out(),
            {10'd0, seq[i-2].dout, seq[i-2].isk, seq[i-2].nit, seq[i-2].derr});
      indata = (i < n) ? seq[i].din : 20'h00000;
    end
  endtask

  // 0xAAAAA is D10.2 twice: balanced, legal at either RD.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b0;
    indata = 20'hAAAAA;
    repeat (2) @(negedge clk);
    chk({tag, "_reset_outputs"}, cur_out(), 32'h0);
    rst = 1'b1;
  endtask

  initial begin
    tbl[0] = mk(20'hAA97C, 16'h4ABC, 2'b01, 2'b00, 2'b00);
    tbl[1] = mk(20'h392AA, 16'h7B4A, 2'b00, 2'b00, 2'b00);
    tbl[2] = mk(20'h15CBC, 16'hF71C, 2'b11, 2'b00, 2'b00);
    tbl[3] = mk(20'h28FB1, 16'h03F1, 2'b00, 2'b00, 2'b00);
    tbl[4] = mk(20'hA0F46, 16'hBC00, 2'b10, 2'b00, 2'b11);
    tbl[5] = mk(20'hC9678, 16'h6527, 2'b00, 2'b00, 2'b11);
    tbl[6] = mk(20'h23FFF, 16'h0000, 2'b00, 2'b11, 2'b00);

    rst = 1'b0;
    indata = 20'h00000;
    #12;
    chk("power_on_reset", cur_out(), 32'h0);
`ifdef GTX_10X8DEC_STATS_EN
    chk("power_on_counters", {err_code_cnt, err_disp_cnt}, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b1;

    // Mixed table: K chars, D.x.7 alternate, dual disparity and code errors.
    do_reset("tbl");
    seq.delete();
    foreach (tbl[i]) seq.push_back(tbl[i]);
    seq.push_back(mk(20'h4D47C, 16'h9FFC, 2'b01, 2'b00, 2'b00));
    seq.push_back(mk(20'h60D7C, 16'h3CBC, 2'b11, 2'b00, 2'b00));
    play("tbl");

    // SATA ALIGN primitive stream.
    do_reset("align");
    seq.delete();
    for (int i = 0; i < 500; i++) begin
      seq.push_back(mk(20'hAA97C, 16'h4ABC, 2'b01, 2'b00, 2'b00));
      seq.push_back(mk(20'h392AA, 16'h7B4A, 2'b00, 2'b00, 2'b00));
    end
    play("align");

    // K28.5 RD+ form after reset: disparity error, then RD- form accepted.
    do_reset("k28p");
    seq.delete();
    seq.push_back(mk(20'hAAA83, 16'h4ABC, 2'b01, 2'b00, 2'b01));
    seq.push_back(mk(20'hAA97C, 16'h4ABC, 2'b01, 2'b00, 2'b00));
    play("k28p");

    // notintable byte must leave RD at + so the RD+ D27.3 that follows is clean.
    do_reset("nit");
    seq.delete();
    seq.push_back(mk(20'hAA97C, 16'h4ABC, 2'b01, 2'b00, 2'b00));
    seq.push_back(mk(20'h55400, 16'hB500, 2'b00, 2'b01, 2'b00));
    seq.push_back(mk(20'h392AA, 16'h7B4A, 2'b00, 2'b00, 2'b00));
    play("nit");

    // Asynchronous reset between edges, then RD- checking restarts.
    do_reset("async");
    @(negedge clk);
    indata = 20'hAA97C;
    @(posedge clk);
    @(posedge clk);
    #3;
    chk("async_pre_reset", cur_out(), {10'd0, 16'h4ABC, 2'b01, 2'b00, 2'b00});
    rst = 1'b0;
    #1;
    chk("async_clear", cur_out(), 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("async_first_gap", cur_out(), 32'h0);
    @(negedge clk);
    chk("async_first_word", cur_out(), {10'd0, 16'h4ABC, 2'b01, 2'b00, 2'b00});

`ifdef GTX_10X8DEC_STATS_EN
    do_reset("stats");
    @(negedge clk);
    indata = 20'h00000;
    repeat (3) @(negedge clk);
    indata = 20'hAAA83;
    @(negedge clk);
    indata = 20'hAAAAA;
    repeat (3) @(negedge clk);
    chk("stats_code_six", {16'd0, err_code_cnt}, 32'd6);
    chk("stats_disp_one", {16'd0, err_disp_cnt}, 32'd1);
    indata = 20'h00000;
    repeat (32768) @(negedge clk);
    indata = 20'hAAAAA;
    repeat (3) @(negedge clk);
    chk("stats_code_sat", {16'd0, err_code_cnt}, 32'h0000FFFF);
    chk("stats_disp_hold", {16'd0, err_disp_cnt}, 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
